trace_capture: RTL and testbench

TRACE_CAPTURE -- requirements
Module: trace_capture

---
 rtl/trace_capture_pkg.sv | 42 ++++
 rtl/trace_classify.sv | 27 ++
 rtl/trace_capture.sv | 126 ++++++++++++
 tb/tb_trace_capture.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/trace_capture_pkg.sv
// Shared class codes, FSM states and trace entry layout for the trace capture block.
package trace_capture_pkg;

  typedef enum logic [2:0] {
    ClsAlu    = 3'd0,
    ClsBranch = 3'd1,
    ClsJump   = 3'd2,
    ClsLoad   = 3'd3,
    ClsStore  = 3'd4,
    ClsSystem = 3'd5,
    ClsMulDiv = 3'd6,
    ClsOther  = 3'd7
  } trace_class_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StPost  = 2'd2,
    StDone  = 2'd3
  } trace_state_e;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  localparam logic [6:0] Funct7MulDiv = 7'b0000001;

  // 67-bit readout word: {class, pc, opcode}
  typedef struct packed {
    trace_class_e cls;
    logic [31:0]  pc;
    logic [31:0]  opcode;
  } trace_entry_t;

endpackage

// File: rtl/trace_classify.sv
// Combinational instruction classifier: maps a retired RV32 instruction word to a trace class.
module trace_classify
  import trace_capture_pkg::*;
(
  input  logic [31:0]  opcode_i,
  output trace_class_e class_o
);

  logic unused_opcode_bits;
  assign unused_opcode_bits = ^opcode_i[24:7];

  always_comb begin
    class_o = ClsOther;
    case (opcode_i[6:0])
      OpcOp:                       class_o = (opcode_i[31:25] == Funct7MulDiv) ? ClsMulDiv
                                                                               : ClsAlu;
      OpcOpImm, OpcLui, OpcAuipc:  class_o = ClsAlu;
      OpcBranch:                   class_o = ClsBranch;
      OpcJal, OpcJalr:             class_o = ClsJump;
      OpcLoad:                     class_o = ClsLoad;
      OpcStore:                    class_o = ClsStore;
      OpcSystem:                   class_o = ClsSystem;
      default:                     class_o = ClsOther;
    endcase
  end

endmodule

// File: rtl/trace_capture.sv
// Retired-instruction trace buffer with PC trigger, post-trigger window, class filter and
// FIFO-order readout once capture is done.
module trace_capture
  import trace_capture_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned POST_TRIGGER = 8,
  parameter logic [7:0]  CLASS_FILTER = 8'hFF,
  localparam int unsigned AW          = $clog2(DEPTH),
  localparam int unsigned CW          = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  input  logic [31:0]   pc_i,
  input  logic [31:0]   opcode_i,
  input  logic          arm_i,
  input  logic          stop_i,
  input  logic          trig_en_i,
  input  logic [31:0]   trig_pc_i,
  output logic          rd_valid_o,
  input  logic          rd_ready_i,
  output logic [66:0]   rd_data_o,
  output logic [1:0]    state_o,
  output logic [CW-1:0] count_o,
  output logic          triggered_o,
  output logic          overflow_o
);

  trace_state_e  state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] post_q;
  logic          triggered_q;
  logic          overflow_q;
  trace_entry_t  mem_q [DEPTH];

  trace_class_e  cls;
  logic          trig_hit;
  logic          capture;
  logic          full;
  logic          pop;

  trace_classify u_classify (
    .opcode_i (opcode_i),
    .class_o  (cls)
  );

  assign trig_hit = (state_q == StArmed) && trig_en_i && valid_i && (pc_i == trig_pc_i);
  // arm_i wipes the buffer this edge, so a concurrent capture must not land in it
  assign capture  = ((state_q == StArmed) || (state_q == StPost)) && valid_i && !arm_i &&
                    (CLASS_FILTER[cls] || trig_hit);
  assign full     = (count_q == CW'(DEPTH));
  assign pop      = rd_valid_o && rd_ready_i;

  // Storage is intentionally not reset
  always_ff @(posedge clk_i) begin
    if (capture) begin
      mem_q[wr_ptr_q] <= '{cls: cls, pc: pc_i, opcode: opcode_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      post_q      <= '0;
      triggered_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (arm_i) begin
      state_q     <= StArmed;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      post_q      <= '0;
      triggered_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (capture) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (full) begin
          overflow_q <= 1'b1;
        end else begin
          count_q <= count_q + 1'b1;
        end
      end
      unique case (state_q)
        StIdle: begin
        end
        StArmed: begin
          if (stop_i) begin
            state_q <= StDone;
          end else if (trig_hit) begin
            triggered_q <= 1'b1;
            post_q      <= CW'(POST_TRIGGER);
            state_q     <= (POST_TRIGGER == 0) ? StDone : StPost;
          end
        end
        StPost: begin
          if (stop_i) begin
            state_q <= StDone;
          end else if (capture) begin
            post_q <= post_q - 1'b1;
            if (post_q == CW'(1)) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          if (pop) begin
            count_q <= count_q - 1'b1;
          end
        end
      endcase
    end
  end

  assign rd_valid_o  = (state_q == StDone) && (count_q != '0);
  // Oldest entry sits count slots behind the write pointer; a full count aliases to wr_ptr
  assign rd_data_o   = mem_q[wr_ptr_q - count_q[AW-1:0]];
  assign state_o     = state_q;
  assign count_o     = count_q;
  assign triggered_o = triggered_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench: classifier vector table plus hand-written capture, trigger, readout and reset
// sequences on two instances differing only in class filter.
module tb_trace_capture;

  localparam logic [31:0] OpAdd  = 32'h003100B3;
  localparam logic [31:0] OpAddi = 32'h00100093;
  localparam logic [31:0] OpLw   = 32'h0000A083;
  localparam logic [31:0] OpSw   = 32'h00112023;

  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, arm_i, stop_i, trig_en_i, rd_ready_i;
  logic [31:0] pc_i, opcode_i, trig_pc_i;

  logic        a_rd_valid, a_trig, a_ovf, b_rd_valid, b_trig, b_ovf;
  logic [66:0] a_rd_data, b_rd_data;
  logic [1:0]  a_state, b_state;
  logic [3:0]  a_count, b_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] op;
    logic [2:0]  cls;
  } cls_vec_t;
  cls_vec_t vecs [14];

  always #5 clk_i = ~clk_i;

  trace_capture #(.DEPTH(8), .POST_TRIGGER(2), .CLASS_FILTER(8'hFF)) u_dut_a (
    .clk_i, .rst_i, .valid_i, .pc_i, .opcode_i, .arm_i, .stop_i, .trig_en_i, .trig_pc_i,
    .rd_valid_o (a_rd_valid), .rd_ready_i, .rd_data_o (a_rd_data), .state_o (a_state),
    .count_o (a_count), .triggered_o (a_trig), .overflow_o (a_ovf)
  );

  trace_capture #(.DEPTH(8), .POST_TRIGGER(2), .CLASS_FILTER(8'h08)) u_dut_b (
    .clk_i, .rst_i, .valid_i, .pc_i, .opcode_i, .arm_i, .stop_i, .trig_en_i, .trig_pc_i,
    .rd_valid_o (b_rd_valid), .rd_ready_i, .rd_data_o (b_rd_data), .state_o (b_state),
    .count_o (b_count), .triggered_o (b_trig), .overflow_o (b_ovf)
  );

  function automatic logic [66:0] ent(input logic [2:0] c, input logic [31:0] pc,
                                      input logic [31:0] op);
    return {c, pc, op};
  endfunction

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic instr(input logic [31:0] pc, input logic [31:0] op);
    valid_i  = 1'b1;
    pc_i     = pc;
    opcode_i = op;
    cyc();
    valid_i  = 1'b0;
  endtask

  task automatic arm();
    arm_i = 1'b1;
    cyc();
    arm_i = 1'b0;
  endtask

  task automatic stop();
    stop_i = 1'b1;
    cyc();
    stop_i = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'h003100B3, 3'd0};  // add
    vecs[1]  = '{32'h403100B3, 3'd0};  // sub
    vecs[2]  = '{32'h00100093, 3'd0};  // addi
    vecs[3]  = '{32'h000010B7, 3'd0};  // lui
    vecs[4]  = '{32'h00001097, 3'd0};  // auipc
    vecs[5]  = '{32'h00000063, 3'd1};  // beq
    vecs[6]  = '{32'h0000006F, 3'd2};  // jal
    vecs[7]  = '{32'h00008067, 3'd2};  // jalr
    vecs[8]  = '{32'h0000A083, 3'd3};  // lw
    vecs[9]  = '{32'h00112023, 3'd4};  // sw
    vecs[10] = '{32'h30001073, 3'd5};  // csrrw
    vecs[11] = '{32'h023100B3, 3'd6};  // mul
    vecs[12] = '{32'h0FF0000F, 3'd7};  // fence
    vecs[13] = '{32'h00000000, 3'd7};  // illegal

    rst_i = 1'b1; valid_i = 1'b0; arm_i = 1'b0; stop_i = 1'b0; trig_en_i = 1'b0;
    rd_ready_i = 1'b0; pc_i = '0; opcode_i = '0; trig_pc_i = '0;
    cyc(); cyc();
    rst_i = 1'b0;
    check("reset_state", 67'(a_state), 67'(0));
    check("reset_count", 67'(a_count), 67'(0));
    check("reset_rd_valid", 67'(a_rd_valid), 67'(0));
    check("reset_flags", 67'({a_trig, a_ovf}), 67'(0));
    instr(32'h10, OpAdd);
    check("idle_no_capture", 67'(a_count), 67'(0));

    // Classifier table; stop in the capture cycle still writes the entry
    for (int i = 0; i < 14; i++) begin
      arm();
      valid_i = 1'b1; pc_i = 32'h1000 + 32'(4 * i); opcode_i = vecs[i].op; stop_i = 1'b1;
      cyc();
      valid_i = 1'b0; stop_i = 1'b0;
      check($sformatf("class_vec%0d", i), a_rd_data, ent(vecs[i].cls, 32'h1000 + 32'(4 * i),
                                                        vecs[i].op));
    end
    check("class_stop_count", 67'(a_count), 67'(1));

    // Basic capture, stop, drain
    arm();
    check("armed_state", 67'(a_state), 67'(1));
    for (int i = 0; i < 4; i++) instr(32'h100 + 32'(4 * i), OpAdd);
    stop();
    check("basic_done", 67'(a_state), 67'(3));
    check("basic_count", 67'(a_count), 67'(4));
    rd_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic_pop%0d", i), a_rd_data, ent(3'd0, 32'h100 + 32'(4 * i), OpAdd));
      cyc();
    end
    rd_ready_i = 1'b0;
    check("basic_empty_valid", 67'(a_rd_valid), 67'(0));
    check("basic_empty_state", 67'(a_state), 67'(3));

    // Wrap, overflow and post-trigger window
    arm();
    trig_en_i = 1'b1; trig_pc_i = 32'h200;
    for (int i = 0; i < 12; i++) instr(32'h1C4 + 32'(4 * i), OpAddi);
    check("wrap_ovf", 67'(a_ovf), 67'(1));
    instr(32'h200, OpAddi);
    check("trig_post_state", 67'({a_state, a_trig}), 67'({2'd2, 1'b1}));
    instr(32'h204, OpAddi);
    check("post_still", 67'(a_state), 67'(2));
    instr(32'h208, OpAddi);
    trig_en_i = 1'b0;
    check("post_done", 67'(a_state), 67'(3));
    check("post_flags", 67'({a_trig, a_ovf}), 67'(2'b11));
    check("post_count", 67'(a_count), 67'(8));
    check("post_oldest", a_rd_data, ent(3'd0, 32'h1E0, OpAddi));

    // Backpressure; a valid instruction in DONE is ignored
    valid_i = 1'b1; pc_i = 32'h20C; opcode_i = OpAddi;
    for (int i = 0; i < 3; i++) begin
      cyc();
      valid_i = 1'b0;
      check($sformatf("bp_hold%0d", i), {a_count, a_rd_data[63:32]}, {4'd8, 32'h1E0});
    end
    rd_ready_i = 1'b1;
    cyc();
    check("bp_pop1", {a_count, a_rd_data[63:32]}, {4'd7, 32'h1E4});
    cyc();
    check("bp_pop2", {a_count, a_rd_data[63:32]}, {4'd6, 32'h1E8});
    rd_ready_i = 1'b0;
    // Drain all but the last entry (1E8, 1EC, 1F0, 200, 204)
    rd_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    rd_ready_i = 1'b0;
    check("last_entry", {a_count, a_rd_data}, {4'd1, ent(3'd0, 32'h208, OpAddi)});

    // Arm concurrent with pop and valid
    arm_i = 1'b1; rd_ready_i = 1'b1; valid_i = 1'b1; pc_i = 32'h300; opcode_i = OpAdd;
    cyc();
    arm_i = 1'b0; rd_ready_i = 1'b0; valid_i = 1'b0;
    check("rearm_state", 67'({a_state, a_count}), 67'({2'd1, 4'd0}));
    check("rearm_flags", 67'({a_trig, a_ovf}), 67'(0));
    stop();
    check("rearm_no_entry", 67'({a_count, a_rd_valid}), 67'(0));

    // Class filter: only loads on instance b
    arm();
    instr(32'h500, OpAdd);
    instr(32'h504, OpLw);
    instr(32'h508, OpSw);
    instr(32'h50C, OpLw);
    stop();
    check("filt_count_a", 67'(a_count), 67'(4));
    check("filt_count_b", 67'(b_count), 67'(2));
    rd_ready_i = 1'b1;
    check("filt_lw0", b_rd_data, ent(3'd3, 32'h504, OpLw));
    cyc();
    check("filt_lw1", b_rd_data, ent(3'd3, 32'h50C, OpLw));
    rd_ready_i = 1'b0;

    // Trigger on a filtered-out store still captures it
    arm();
    trig_en_i = 1'b1; trig_pc_i = 32'h608;
    instr(32'h600, OpAdd);
    instr(32'h604, OpLw);
    instr(32'h608, OpSw);
    instr(32'h60C, OpAdd);
    check("filt_post_b", 67'({b_state, b_count}), 67'({2'd2, 4'd2}));
    instr(32'h610, OpLw);
    instr(32'h614, OpLw);
    trig_en_i = 1'b0;
    check("filt_done_b", 67'({b_state, b_count, b_trig, b_ovf}), 67'({2'd3, 4'd4, 2'b10}));
    check("filt_done_a", 67'({a_state, a_count}), 67'({2'd3, 4'd5}));
    rd_ready_i = 1'b1;
    cyc();
    rd_ready_i = 1'b0;
    check("filt_trig_sw", {b_rd_valid, b_rd_data}, {1'b1, ent(3'd4, 32'h608, OpSw)});

    // Reset mid-POST
    arm();
    trig_en_i = 1'b1; trig_pc_i = 32'h400;
    for (int i = 0; i < 5; i++) instr(32'h3F4 + 32'(4 * i), OpAdd);
    check("rst_pre", 67'({a_state, a_count}), 67'({2'd2, 4'd5}));
    rst_i = 1'b1; valid_i = 1'b1; pc_i = 32'h408;
    cyc();
    rst_i = 1'b0; valid_i = 1'b0; trig_en_i = 1'b0;
    check("rst_post", 67'({a_state, a_count, a_rd_valid, a_trig, a_ovf}), 67'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
